// File: rtl/bn_pkg.sv
// Shared BN-pipeline constants and counter types for the BN-ADD to BN-MULT packer.
// Latency: n/a (package).
// Backpressure: n/a (package).
package bn_pkg;

    localparam int BN_BEAT_W   = 256;   // one BN-ADD beat: 16 ch x 16 bit
    localparam int BN_BEATS    = 4;     // beats per BN-MULT word
    localparam int BN_WORD_W   = 1024;  // 64 ch x 16 bit
    localparam int BN_MULT_GAP = 10;    // min cycles between BN-MULT words, start to start

    typedef logic [2:0] fill_cnt_t;     // 0..4 beats held in the fill buffer
    typedef logic [3:0] gap_cnt_t;      // cycles left before the output may reload

endpackage : bn_pkg

// File: rtl/bn_add_res_packer.sv
// Packs four 256-bit BN-ADD beats into one 1024-bit word with a one-cycle valid pulse to BN-MULT.
// Latency: pulse in the cycle after the 4th beat is accepted when the output is free; pulses are spaced >= GAP cycles.
// Backpressure: in_rdy drops while a complete word waits for the gap to expire; derived from registered state only.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   in_data      BN-ADD beat, beat 0 lands in word bits [BEAT_W-1:0]
//   in_v/in_rdy  beat handshake, transfer on in_v && in_rdy
//   flush        (BNPACK_FLUSH_EN only) close a partial word, unfilled slices read as zero
//   pack_res_w   packed word, held stable between loads
//   pack_res_v_w one-cycle valid pulse per loaded word
// Optional feature macro: BNPACK_FLUSH_EN (adds the flush port).
module bn_add_res_packer
    import bn_pkg::*;
#(
    parameter int BEAT_W = BN_BEAT_W,
    parameter int BEATS  = BN_BEATS,
    parameter int GAP    = BN_MULT_GAP
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BEAT_W-1:0]       in_data,
    input  logic                    in_v,
    output logic                    in_rdy,
`ifdef BNPACK_FLUSH_EN
    input  logic                    flush,
`endif
    output logic [BEAT_W*BEATS-1:0] pack_res_w,
    output logic                    pack_res_v_w
);

    localparam int        WORD_W     = BEAT_W * BEATS;
    localparam fill_cnt_t FILL_FULL  = fill_cnt_t'(BEATS);
    localparam gap_cnt_t  GAP_RELOAD = gap_cnt_t'(GAP - 1);

    fill_cnt_t          fill_cnt_q, fill_cnt_d;
    logic [WORD_W-1:0]  fill_buf_q, fill_buf_d;
    logic [WORD_W-1:0]  out_buf_q,  out_buf_d;
    gap_cnt_t           gap_cnt_q,  gap_cnt_d;
    logic               vld_q,      vld_d;

    // Intermediate view of the fill side after this edge's beat (and flush),
    // before deciding whether the word moves to the output.
    fill_cnt_t          fill_cnt_nxt;
    logic [WORD_W-1:0]  fill_buf_nxt;
    logic               beat_acc;
    logic               load;

    // rst is folded in so upstream sees not-ready throughout reset.
    assign in_rdy   = rst && (fill_cnt_q != FILL_FULL);
    assign beat_acc = in_v && in_rdy;

    always_comb begin
        fill_cnt_nxt = fill_cnt_q;
        fill_buf_nxt = fill_buf_q;

        if (beat_acc) begin
            for (int k = 0; k < BEATS; k++) begin
                if (fill_cnt_q == fill_cnt_t'(k)) begin
                    fill_buf_nxt[k*BEAT_W +: BEAT_W] = in_data;
                end
            end
            fill_cnt_nxt = fill_cnt_q + fill_cnt_t'(1);
        end

`ifdef BNPACK_FLUSH_EN
        // A partial word is closed by zeroing the slices not yet written;
        // stale data from an earlier word may still sit there.
        if (flush && (fill_cnt_nxt != '0) && (fill_cnt_nxt != FILL_FULL)) begin
            for (int k = 0; k < BEATS; k++) begin
                if (fill_cnt_t'(k) >= fill_cnt_nxt) begin
                    fill_buf_nxt[k*BEAT_W +: BEAT_W] = '0;
                end
            end
            fill_cnt_nxt = FILL_FULL;
        end
`endif
    end

    // Covers both the bypass case (4th beat this edge: fill_buf_nxt already
    // holds in_data in the top slice) and the deferred load from fill_buf.
    assign load = (gap_cnt_q == '0) && (fill_cnt_nxt == FILL_FULL);

    always_comb begin
        fill_buf_d = fill_buf_nxt;
        fill_cnt_d = fill_cnt_nxt;
        out_buf_d  = out_buf_q;
        vld_d      = 1'b0;
        gap_cnt_d  = (gap_cnt_q != '0) ? gap_cnt_q - gap_cnt_t'(1) : gap_cnt_q;

        if (load) begin
            out_buf_d  = fill_buf_nxt;
            fill_cnt_d = '0;
            gap_cnt_d  = GAP_RELOAD;
            vld_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_cnt_q <= '0;
            fill_buf_q <= '0;
            out_buf_q  <= '0;
            gap_cnt_q  <= '0;
            vld_q      <= 1'b0;
        end else begin
            fill_cnt_q <= fill_cnt_d;
            fill_buf_q <= fill_buf_d;
            out_buf_q  <= out_buf_d;
            gap_cnt_q  <= gap_cnt_d;
            vld_q      <= vld_d;
        end
    end

    assign pack_res_w   = out_buf_q;
    assign pack_res_v_w = vld_q;

endmodule : bn_add_res_packer

// File: tb/tb_bn_add_res_packer.sv
// Self-checking bench for bn_add_res_packer against a queue-based behavioural model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench); define BNPACK_FLUSH_EN to also exercise flush.
module tb_bn_add_res_packer;

    localparam int GAP = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [255:0]  in_data;
    logic          in_v;
    logic          in_rdy;
    logic          flush;
    logic [1023:0] pack_res_w;
    logic          pack_res_v_w;

    always #5 clk = ~clk;

    bn_add_res_packer dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_v         (in_v),
        .in_rdy       (in_rdy),
`ifdef BNPACK_FLUSH_EN
        .flush        (flush),
`endif
        .pack_res_w   (pack_res_w),
        .pack_res_v_w (pack_res_v_w)
    );

    // Reference model: beats waiting for a word, last word emitted, and the
    // edge index of the last load (spacing is plain edge arithmetic).
    logic [255:0]  mq[$];
    logic [1023:0] m_word;
    logic          m_vld;
    longint        edge_n;
    longint        last_load;
    longint        pulse_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int lane;
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            lane = 0;
            for (int i = 31; i >= 0; i--) begin
                if (obs[i*32 +: 32] !== exp[i*32 +: 32]) lane = i;
            end
            $display("FAIL %s @edge %0d: lane %0d got %h expected %h",
                     tag, edge_n, lane, obs[lane*32 +: 32], exp[lane*32 +: 32]);
        end
    endtask

    function automatic logic [255:0] rep16(input logic [15:0] x);
        return {16{x}};
    endfunction

    function automatic logic [255:0] rand_beat();
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_word    = '0;
        m_vld     = 1'b0;
        last_load = -1000;
    endtask

    // One clock cycle: drive inputs, check in_rdy, clock, update model, check outputs.
    task automatic cycle(input logic v, input logic [255:0] d, input logic fl);
        in_v    = v;
        in_data = d;
        flush   = fl;
        #1;
        check_val("in_rdy", {1023'b0, in_rdy}, {1023'b0, (mq.size() < 4)});
        @(posedge clk);
        edge_n++;
        m_vld = 1'b0;
        if (v && mq.size() < 4) mq.push_back(d);
`ifdef BNPACK_FLUSH_EN
        if (fl && mq.size() >= 1 && mq.size() <= 3) begin
            while (mq.size() < 4) mq.push_back('0);
        end
`endif
        if (mq.size() == 4 && (edge_n - last_load) >= GAP) begin
            m_word    = {mq[3], mq[2], mq[1], mq[0]};
            mq.delete();
            last_load = edge_n;
            m_vld     = 1'b1;
        end
        #1;
        if (pack_res_v_w === 1'b1) pulse_q.push_back(edge_n);
        check_val("pulse", {1023'b0, pack_res_v_w}, {1023'b0, m_vld});
        check_val("word", pack_res_w, m_word);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] b;
        int acc;
        int dens;

        edge_n  = 0;
        rst     = 1'b0;
        in_v    = 1'b0;
        in_data = '0;
        flush   = 1'b0;
        model_reset();

        // Reset state
        #12;
        check_val("rst_pulse", {1023'b0, pack_res_v_w}, '0);
        check_val("rst_word", pack_res_w, '0);
        check_val("rst_rdy", {1023'b0, in_rdy}, '0);
        @(posedge clk); edge_n++;
        #1 rst = 1'b1;

        // Beats 1..4 on consecutive cycles
        cycle(1'b1, rep16(16'h0001), 1'b0);
        cycle(1'b1, rep16(16'h0002), 1'b0);
        cycle(1'b1, rep16(16'h0003), 1'b0);
        cycle(1'b1, rep16(16'h0004), 1'b0);
        check_val("t1_pulse", {1023'b0, pack_res_v_w}, 1024'd1);
        check_val("t1_word", pack_res_w,
                  {rep16(16'h0004), rep16(16'h0003), rep16(16'h0002), rep16(16'h0001)});
        idle(12);

        // 8 beats back to back: second pulse exactly GAP after the first
        pulse_q.delete();
        acc = 0;
        b   = rand_beat();
        while (acc < 8) begin
            if (mq.size() < 4) begin
                cycle(1'b1, b, 1'b0);
                acc++;
                b = rand_beat();
            end else begin
                cycle(1'b1, b, 1'b0);
            end
        end
        idle(15);
        check_val("t2_npulse", 1024'(pulse_q.size()), 1024'd2);
        if (pulse_q.size() == 2)
            check_val("t2_spacing", 1024'(pulse_q[1] - pulse_q[0]), 1024'(GAP));

        // in_v alternating
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, rand_beat(), 1'b0);
            cycle(1'b0, rand_beat(), 1'b0);
        end
        idle(12);

        // Asynchronous reset in the middle of a partial fill
        cycle(1'b1, rep16(16'hdead), 1'b0);
        cycle(1'b1, rep16(16'hbeef), 1'b0);
        #2 rst = 1'b0;
        #1;
        check_val("mid_rst_pulse", {1023'b0, pack_res_v_w}, '0);
        check_val("mid_rst_word", pack_res_w, '0);
        check_val("mid_rst_rdy", {1023'b0, in_rdy}, '0);
        model_reset();
        @(posedge clk); edge_n++;
        #1 rst = 1'b1;
        cycle(1'b1, rep16(16'h0011), 1'b0);
        cycle(1'b1, rep16(16'h0022), 1'b0);
        cycle(1'b1, rep16(16'h0033), 1'b0);
        cycle(1'b1, rep16(16'h0044), 1'b0);
        check_val("post_rst_word", pack_res_w,
                  {rep16(16'h0044), rep16(16'h0033), rep16(16'h0022), rep16(16'h0011)});
        idle(12);

`ifdef BNPACK_FLUSH_EN
        // Flush of a 3-beat partial word, then a flush with nothing buffered
        cycle(1'b1, rep16(16'h000a), 1'b0);
        cycle(1'b1, rep16(16'h000b), 1'b0);
        cycle(1'b1, rep16(16'h000c), 1'b0);
        cycle(1'b0, '0, 1'b1);
        check_val("flush_pulse", {1023'b0, pack_res_v_w}, 1024'd1);
        check_val("flush_word", pack_res_w,
                  {256'b0, rep16(16'h000c), rep16(16'h000b), rep16(16'h000a)});
        idle(12);
        pulse_q.delete();
        cycle(1'b0, '0, 1'b1);
        idle(12);
        check_val("flush_empty", 1024'(pulse_q.size()), '0);
`endif

        // Word held stable for 50 idle cycles
        for (int i = 0; i < 4; i++) cycle(1'b1, rand_beat(), 1'b0);
        pulse_q.delete();
        idle(50);
        check_val("hold_npulse", 1024'(pulse_q.size()), '0);

        // Randomized traffic with varying density
        for (int blk = 0; blk < 6; blk++) begin
            dens = 20 + blk * 16;
            for (int i = 0; i < 500; i++) begin
`ifdef BNPACK_FLUSH_EN
                cycle(($urandom_range(99) < dens), rand_beat(), ($urandom_range(15) == 0));
`else
                cycle(($urandom_range(99) < dens), rand_beat(), 1'b0);
`endif
            end
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_bn_add_res_packer
